// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one combinational ALU between two
//               valid/ready requesters, one operation in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_a,
    input  logic [DATA_WIDTH-1:0]    req0_b,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic [DATA_WIDTH-1:0]    rsp0_result,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_a,
    input  logic [DATA_WIDTH-1:0]    req1_b,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [DATA_WIDTH-1:0]    rsp1_result,
    output logic [DATA_WIDTH-1:0]    alu_src_a,
    output logic [DATA_WIDTH-1:0]    alu_src_b,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_last_grant;
    logic                     r_owner;
    logic [DATA_WIDTH-1:0]    r_a;
    logic [DATA_WIDTH-1:0]    r_b;
    logic [DATA_WIDTH-1:0]    r_result;
    logic [OPCODE_LENGTH-1:0] r_op;
    logic                     w_grant0;
    logic                     w_grant1;
    logic                     w_accept;
    logic                     w_rsp_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        rsp0_result = '0;
        rsp1_result = '0;
        w_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

        // Outputs are forced quiet while reset is held, whatever the state.
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (req0_valid && req1_valid) begin
                        // Tie: the requester not served last time wins.
                        w_grant0 = r_last_grant;
                        w_grant1 = !r_last_grant;
                    end else begin
                        w_grant0 = req0_valid;
                        w_grant1 = req1_valid;
                    end
                    if (w_grant0 || w_grant1) begin
                        w_state_nxt = S_EXEC;
                    end
                end
                S_EXEC: begin
                    w_state_nxt = S_RESP;
                end
                S_RESP: begin
                    rsp0_valid  = !r_owner;
                    rsp1_valid  = r_owner;
                    rsp0_result = r_owner ? '0 : r_result;
                    rsp1_result = r_owner ? r_result : '0;
                    if (w_rsp_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign w_accept   = w_grant0 | w_grant1;
    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_result     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a          <= w_grant1 ? req1_a  : req0_a;
                r_b          <= w_grant1 ? req1_b  : req0_b;
                r_op         <= w_grant1 ? req1_op : req0_op;
                r_owner      <= w_grant1;
                r_last_grant <= w_grant1;
            end
            if (r_state == S_EXEC) begin
                r_result <= alu_result;
            end
        end
    end

    assign alu_src_a = r_a;
    assign alu_src_b = r_b;
    assign alu_op    = r_op;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench: vector table, directed corner sequences
//               and a randomized run against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [DW-1:0] req0_a, req0_b, rsp0_result;
    logic [OW-1:0] req0_op;
    logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [DW-1:0] req1_a, req1_b, rsp1_result;
    logic [OW-1:0] req1_op;
    logic [DW-1:0] alu_src_a, alu_src_b, alu_result;
    logic [OW-1:0] alu_op;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op), .rsp0_valid(rsp0_valid),
        .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op), .rsp1_valid(rsp1_valid),
        .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .alu_result(alu_result)
    );

    // Environment ALU (the shared resource itself).
    function automatic logic [DW-1:0] alu_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [OW-1:0] op);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a - b;
            4'b0100: return a ^ b;
            4'b0101: return a << b[4:0];
            4'b0110: return a >> b[4:0];
            4'b0111: return $signed(a) >>> b[4:0];
            4'b1000: return {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1111: return b;
            default: return '0;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_src_a, alu_src_b, alu_op);

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int sel, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [OW-1:0] op);
        if (sel == 0) begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    typedef struct {
        int            sel;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [OW-1:0] op;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin #200000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

    initial begin
        int cyc, ng;
        int got[4];
        idle_inputs();
        do_reset();

        // ---- reset state ----
        #1;
        check("reset_req0_ready", req0_ready, 0);
        check("reset_rsp0_valid", rsp0_valid, 0);
        check("reset_alu_src_a", alu_src_a, 0);

        // ---- vector table: single requester operations ----
        vecs[0] = '{0, 32'd5,          32'd3,          4'b0010, 32'd8};
        vecs[1] = '{1, 32'h8000_0000,  32'd4,          4'b0111, 32'hF800_0000};
        vecs[2] = '{1, 32'hDEAD_BEEF,  32'h1234_5000,  4'b1111, 32'h1234_5000};
        vecs[3] = '{0, 32'hFFFF_FFFF,  32'd1,          4'b0010, 32'h0};
        vecs[4] = '{1, 32'h0000_1234,  32'h0000_5678,  4'b1010, 32'h0};
        vecs[5] = '{0, 32'd10,         32'd4,          4'b0011, 32'd6};
        for (int i = 0; i < 6; i++) begin
            set_req(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].op);
            rsp0_ready = 1; rsp1_ready = 1;
            #1;
            cyc = 0;
            while (!(vecs[i].sel == 0 ? req0_ready : req1_ready) && cyc < 10) begin
                tick(); cyc++;
            end
            check("vec_accept", (vecs[i].sel == 0) ? req0_ready : req1_ready, 1);
            tick();                                   // EXEC
            req0_valid = 0; req1_valid = 0;
            #1;
            check("vec_exec_no_rsp", rsp0_valid | rsp1_valid, 0);
            check("vec_alu_src_a", alu_src_a, vecs[i].a);
            check("vec_alu_src_b", alu_src_b, vecs[i].b);
            check("vec_alu_op", alu_op, vecs[i].op);
            tick();                                   // RESP
            #1;
            check("vec_rsp_valid", (vecs[i].sel == 0) ? rsp0_valid : rsp1_valid, 1);
            check("vec_rsp_result", (vecs[i].sel == 0) ? rsp0_result : rsp1_result, vecs[i].exp);
            check("vec_other_valid", (vecs[i].sel == 0) ? rsp1_valid : rsp0_valid, 0);
            tick();                                   // back in IDLE
        end

        // ---- tie right after reset: req0 first, then req1 ----
        idle_inputs();
        do_reset();
        set_req(0, 32'd10, 32'd4, 4'b0011);
        set_req(1, 32'hF0, 32'h3C, 4'b0000);
        rsp0_ready = 1; rsp1_ready = 1;
        #1;
        check("tie_req0_ready", req0_ready, 1);
        check("tie_req1_ready", req1_ready, 0);
        tick(); req0_valid = 0; #1;
        check("tie_exec_req1_ready", req1_ready, 0);
        tick(); #1;
        check("tie_rsp0_valid", rsp0_valid, 1);
        check("tie_rsp0_result", rsp0_result, 32'd6);
        tick(); #1;
        check("tie_req1_granted", req1_ready, 1);
        tick(); req1_valid = 0; tick(); #1;
        check("tie_rsp1_valid", rsp1_valid, 1);
        check("tie_rsp1_result", rsp1_result, 32'h30);
        check("tie_rsp0_quiet", rsp0_valid, 0);
        tick();

        // ---- both valid continuously: alternating grants ----
        set_req(0, 32'd1, 32'd2, 4'b0010);
        set_req(1, 32'd7, 32'd3, 4'b0011);
        ng = 0; cyc = 0;
        while (ng < 4 && cyc < 40) begin
            #1;
            if (req0_ready && req1_ready) check("rr_both_ready", 1, 0);
            if (req0_ready) begin got[ng] = 0; ng++; end
            else if (req1_ready) begin got[ng] = 1; ng++; end
            tick(); cyc++;
        end
        check("rr_grant_count", ng, 4);
        for (int i = 0; i < 4; i++) check("rr_grant_order", got[i], i % 2);
        req0_valid = 0; req1_valid = 0;
        tick(); tick(); tick();

        // ---- response back-pressure ----
        rsp0_ready = 0; rsp1_ready = 0;
        set_req(0, 32'd5, 32'd3, 4'b0010);
        #1;
        check("bp_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        set_req(1, 32'h10, 32'h20, 4'b0010);
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_rsp0_valid", rsp0_valid, 1);
            check("bp_rsp0_result", rsp0_result, 32'd8);
            check("bp_req_ready", req0_ready | req1_ready, 0);
            tick();
        end
        rsp0_ready = 1;
        #1;
        check("bp_rsp0_hold", rsp0_valid, 1);
        tick();
        rsp0_ready = 0;
        #1;
        check("bp_req1_granted", req1_ready, 1);
        check("bp_rsp0_done", rsp0_valid, 0);
        tick(); req1_valid = 0; rsp1_ready = 1;
        tick(); #1;
        check("bp_rsp1_result", rsp1_result, 32'h30);
        tick();

        // ---- reset during EXEC ----
        idle_inputs();
        set_req(0, 32'd9, 32'd9, 4'b0010);
        tick();                                       // EXEC for req0
        reset = 1;
        set_req(0, 32'd1, 32'd1, 4'b0010);
        set_req(1, 32'd2, 32'd2, 4'b0010);
        tick();
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp_valid", rsp0_valid | rsp1_valid, 0);
        check("rst_rsp_result", rsp0_result | rsp1_result, 0);
        check("rst_alu_a", alu_src_a, 0);
        check("rst_alu_b", alu_src_b, 0);
        check("rst_alu_op", alu_op, 0);
        reset = 0;
        #1;
        check("rst_tie_req0", req0_ready, 1);
        check("rst_tie_req1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            check("rst_dropped_op", rsp0_valid | rsp1_valid, 0);
        end

        // ---- randomized run against a transaction-level model ----
        begin
            bit            pend[2];
            logic [DW-1:0] ra[2], rb[2];
            logic [OW-1:0] rop[2];
            bit            inflight, rr[2];
            int            owner, last, age, g;
            logic [DW-1:0] exp_res;
            logic [OW-1:0] oplist[11];
            oplist = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF, 4'hB};
            idle_inputs();
            do_reset();
            pend = '{0, 0}; inflight = 0; owner = 0; last = 1; age = 0; exp_res = '0;
            for (int c = 0; c < 500; c++) begin
                for (int r = 0; r < 2; r++) begin
                    if (!pend[r] && ($urandom % 3 == 0)) begin
                        pend[r] = 1;
                        ra[r] = $urandom; rb[r] = $urandom;
                        rop[r] = oplist[$urandom_range(0, 10)];
                    end else if (pend[r] && ($urandom % 10 == 0)) begin
                        pend[r] = 0;                  // requester withdraws
                    end
                    rr[r] = ($urandom % 2) == 1;
                end
                req0_valid = pend[0]; req0_a = ra[0]; req0_b = rb[0]; req0_op = rop[0];
                req1_valid = pend[1]; req1_a = ra[1]; req1_b = rb[1]; req1_op = rop[1];
                rsp0_ready = rr[0]; rsp1_ready = rr[1];
                #1;
                g = -1;
                if (!inflight) begin
                    if (pend[0] && pend[1]) g = (last == 0) ? 1 : 0;
                    else if (pend[0])       g = 0;
                    else if (pend[1])       g = 1;
                end
                check("rnd_req0_ready", req0_ready, g == 0);
                check("rnd_req1_ready", req1_ready, g == 1);
                check("rnd_rsp0_valid", rsp0_valid, inflight && age >= 2 && owner == 0);
                check("rnd_rsp1_valid", rsp1_valid, inflight && age >= 2 && owner == 1);
                check("rnd_rsp0_result", rsp0_result,
                      (inflight && age >= 2 && owner == 0) ? exp_res : '0);
                check("rnd_rsp1_result", rsp1_result,
                      (inflight && age >= 2 && owner == 1) ? exp_res : '0);
                tick();
                if (inflight) begin
                    if (age >= 2 && rr[owner]) inflight = 0;
                    else age++;
                end
                if (g >= 0) begin
                    inflight = 1; age = 1; owner = g; last = g;
                    exp_res = alu_model(ra[g], rb[g], rop[g]);
                    pend[g] = 0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
